// File: rtl/stopwatch_pkg.sv
// Shared state encodings, BCD digit limits and the count boundary compares
// used by the stopwatch controller.
package stopwatch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN_UP   = 3'd1,
      ST_RUN_DOWN = 3'd2,
      ST_PAUSED   = 3'd3,
      ST_EXPIRED  = 3'd4
   } state_t;

   localparam logic [3:0] MAX_TENTHS = 4'd9;
   localparam logic [3:0] MAX_ONES   = 4'd9;
   localparam logic [3:0] MAX_TENS   = 4'd5;
   localparam logic [3:0] MAX_MIN    = 4'd9;

   function automatic logic is_zero(input logic [3:0] tenths, input logic [3:0] ones,
                                    input logic [3:0] tens, input logic [3:0] mins);
      return (tenths == 4'd0) && (ones == 4'd0) && (tens == 4'd0) && (mins == 4'd0);
   endfunction

   function automatic logic is_max(input logic [3:0] tenths, input logic [3:0] ones,
                                   input logic [3:0] tens, input logic [3:0] mins);
      return (tenths == MAX_TENTHS) && (ones == MAX_ONES) &&
             (tens == MAX_TENS) && (mins == MAX_MIN);
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Button front end: multi-flop synchronizer followed by a rising-edge
// detector, giving one pulse per press however long the button is held.
module btn_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: button commands, tenth-second tick,
// direction control, zero/max stop and lap hold for the BCD counter.
//
//   state       | meaning
//   ------------+-----------------------------------------------
//   ST_IDLE     | stopped, counter may be cleared with stop
//   ST_RUN_UP   | counting up on every tick
//   ST_RUN_DOWN | counting down on every tick
//   ST_PAUSED   | counting held, resume or clear
//   ST_EXPIRED  | hit 0:00.0 counting down or 9:59.9 counting up
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV    = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_btn,
   input  logic       stop_btn,
   input  logic       mode_btn,
   input  logic       lap_btn,
   input  logic [3:0] Tenths_Seconds,
   input  logic [3:0] Ones_Seconds,
   input  logic [3:0] Tens_Seconds,
   input  logic [3:0] Minutes,
   output logic       count_en,
   output logic       Countdown,
   output logic       clear_cnt,
   output logic       lap_hold,
   output logic       expired,
   output logic [2:0] state
);

   localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TICK_DIV - 1);

   logic start_p, stop_p, mode_p, lap_p;

   btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start (.clk(clk), .reset(reset), .btn(start_btn), .pulse(start_p));
   btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stop  (.clk(clk), .reset(reset), .btn(stop_btn),  .pulse(stop_p));
   btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mode  (.clk(clk), .reset(reset), .btn(mode_btn),  .pulse(mode_p));
   btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lap   (.clk(clk), .reset(reset), .btn(lap_btn),   .pulse(lap_p));

   state_t           state_q, state_d;
   logic             dir_q, dir_d;
   logic             lap_q, lap_d;
   logic             cen_d, clr_d;
   logic [CNT_W-1:0] tick_cnt_q;
   logic             run_st, tick, at_zero, at_max;

   assign run_st  = (state_q == ST_RUN_UP) || (state_q == ST_RUN_DOWN);
   assign tick    = run_st && (tick_cnt_q == '0);
   assign at_zero = is_zero(Tenths_Seconds, Ones_Seconds, Tens_Seconds, Minutes);
   assign at_max  = is_max(Tenths_Seconds, Ones_Seconds, Tens_Seconds, Minutes);

   // Down-counter reloads outside the run states so the first tick lands
   // TICK_DIV cycles after entering a run; a direction flip does not reload.
   always_ff @(posedge clk) begin
      if (reset || !run_st || tick) begin
         tick_cnt_q <= CNT_LOAD;
      end else begin
         tick_cnt_q <= tick_cnt_q - 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      lap_d   = lap_q;
      cen_d   = 1'b0;
      clr_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (stop_p) begin
               clr_d = 1'b1;
            end else if (start_p) begin
               state_d = dir_q ? ST_RUN_DOWN : ST_RUN_UP;
            end else if (mode_p) begin
               dir_d = ~dir_q;
            end
         end
         ST_RUN_UP, ST_RUN_DOWN: begin
            if (stop_p) begin
               state_d = ST_PAUSED;
            end else begin
               if (!start_p && mode_p) begin
                  dir_d   = ~dir_q;
                  state_d = dir_q ? ST_RUN_UP : ST_RUN_DOWN;
               end
               // Boundary follows the direction the counter will actually see.
               if (tick) begin
                  if (dir_d ? at_zero : at_max) begin
                     state_d = ST_EXPIRED;
                  end else begin
                     cen_d = 1'b1;
                  end
               end
            end
         end
         ST_PAUSED: begin
            if (stop_p) begin
               state_d = ST_IDLE;
               clr_d   = 1'b1;
            end else if (start_p) begin
               state_d = dir_q ? ST_RUN_DOWN : ST_RUN_UP;
            end else if (mode_p) begin
               dir_d = ~dir_q;
            end
         end
         ST_EXPIRED: begin
            if (start_p || stop_p) begin
               state_d = ST_IDLE;
               clr_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (lap_p && (run_st || (state_q == ST_PAUSED))) begin
         lap_d = ~lap_q;
      end
      if (state_d == ST_IDLE) begin
         lap_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         dir_q     <= 1'b0;
         lap_q     <= 1'b0;
         count_en  <= 1'b0;
         clear_cnt <= 1'b0;
         expired   <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         lap_q     <= lap_d;
         count_en  <= cen_d;
         clear_cnt <= clr_d;
         expired   <= (state_d == ST_EXPIRED);
      end
   end

   assign state     = state_q;
   assign Countdown = dir_q;
   assign lap_hold  = lap_q;

endmodule
